// File: rtl/fifo_burst_drain_arbiter.sv
// Round-robin drain of NUM_SRC FWFT FIFOs into one tagged output stream.
// Each grant moves exactly PKT_LEN beats through a one-entry output buffer.
module fifo_burst_drain_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16,
  parameter int ID_W       = $clog2(NUM_SRC)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_read_enable,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_W-1:0]               out_src_id,
  output logic                          out_last,
  output logic                          busy
);

  localparam int CNT_W = $clog2(PKT_LEN) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [ID_W-1:0]       out_src_id_q, out_src_id_d;
  logic                  out_last_q, out_last_d;

  logic                  pop;
  logic                  is_last;
  logic                  any_req;
  logic [ID_W-1:0]       sel;
  logic [ID_W-1:0]       scan_idx;

  // Scan starts just after the last served source so every requester is reached within NUM_SRC packets.
  always_comb begin
    any_req  = 1'b0;
    sel      = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      scan_idx = ID_W'((int'(last_grant_q) + k) % NUM_SRC);
      if (!any_req && src_valid[scan_idx]) begin
        any_req = 1'b1;
        sel     = scan_idx;
      end
    end
  end

  assign is_last = (beat_cnt_q == CNT_W'(PKT_LEN - 1));

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_src_id_d = out_src_id_q;
    out_last_d   = out_last_q;
    src_read_enable = '0;

    pop = (state_q == BURST) && src_valid[grant_q] && (!out_valid_q || out_ready);
    if (pop) src_read_enable[grant_q] = 1'b1;

    if (out_ready && !pop) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d    = sel;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // A dry source simply stalls here; the packet is never abandoned or interleaved.
        if (pop) begin
          out_data_d   = src_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
          out_src_id_d = grant_q;
          out_valid_d  = 1'b1;
          out_last_d   = is_last;
          if (is_last) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_src_id_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_src_id_q <= out_src_id_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_src_id = out_src_id_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q == BURST) || out_valid_q;

endmodule
